// File: rtl/clk_run_ctrl.sv
// rtl/clk_run_ctrl.sv - run/halt/single-step controller for the CPU clock domain
module clk_run_ctrl #(
  parameter int DIV_W    = 8,
  parameter int DEF_DIV  = 3,
  parameter int STEP_W   = 16,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              cpu_ce,
  output logic              dclk,
  output logic              cpu_rst,
  output logic              running,
  output logic              step_done,
  output logic [31:0]       cycle_cnt
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [1:0] OP_HALT    = 2'b00;
  localparam logic [1:0] OP_RUN     = 2'b01;
  localparam logic [1:0] OP_STEP    = 2'b10;
  localparam logic [1:0] OP_SET_DIV = 2'b11;
  localparam logic [DIV_W-1:0]  DIV_ONE  = 1;
  localparam logic [STEP_W-1:0] STEP_ONE = 1;
  localparam logic [HW-1:0]     HOLD_ONE = 1;
  localparam logic [HW-1:0]     HOLD_END = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {S_HOLD, S_HALT, S_RUN, S_STEP} state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  div, pcnt;
  logic [STEP_W-1:0] remaining, remaining_d;
  logic [HW-1:0]     hold_cnt, hold_cnt_d;
  logic              cpu_rst_d, step_done_d;
  logic              tick, accept, issue;

  assign tick      = (pcnt == div);
  assign cmd_ready = !rst && (state != S_HOLD);
  assign accept    = cmd_valid && cmd_ready;
  assign running   = (state == S_RUN) || (state == S_STEP);
  // The tick on an accept edge is judged against the state before the command.
  assign issue     = tick && running;

  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    hold_cnt_d  = hold_cnt;
    cpu_rst_d   = cpu_rst;
    step_done_d = 1'b0;

    case (state)
      S_HOLD: begin
        if (tick) begin
          if (hold_cnt == HOLD_END) begin
            state_d   = S_HALT;
            cpu_rst_d = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt + HOLD_ONE;
          end
        end
      end
      S_STEP: begin
        if (tick) begin
          remaining_d = remaining - STEP_ONE;
          if (remaining == STEP_ONE) begin
            state_d     = S_HALT;
            step_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Commands override the tick-driven transition; accept never happens in HOLD.
    if (accept) begin
      case (cmd_op)
        OP_HALT: state_d = S_HALT;
        OP_RUN:  state_d = S_RUN;
        OP_STEP: begin
          if (cmd_arg == '0) begin
            state_d     = S_HALT;
            step_done_d = 1'b1;
          end else begin
            state_d     = S_STEP;
            remaining_d = cmd_arg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HOLD;
      remaining <= '0;
      hold_cnt  <= '0;
      cpu_rst   <= 1'b1;
      step_done <= 1'b0;
      cpu_ce    <= 1'b0;
      dclk      <= 1'b0;
      cycle_cnt <= '0;
      div       <= DIV_W'(DEF_DIV);
      pcnt      <= '0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      hold_cnt  <= hold_cnt_d;
      cpu_rst   <= cpu_rst_d;
      step_done <= step_done_d;
      cpu_ce    <= issue;
      if (issue) begin
        dclk      <= ~dclk;
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (accept && (cmd_op == OP_SET_DIV)) begin
        div  <= cmd_arg[DIV_W-1:0];
        pcnt <= '0;
      end else if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + DIV_ONE;
      end
    end
  end

endmodule

// File: tb/tb_clk_run_ctrl.sv
// tb/tb_clk_run_ctrl.sv - directed bench for clk_run_ctrl
module tb_clk_run_ctrl;

  localparam logic [1:0] OP_HALT    = 2'b00;
  localparam logic [1:0] OP_RUN     = 2'b01;
  localparam logic [1:0] OP_STEP    = 2'b10;
  localparam logic [1:0] OP_SET_DIV = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_arg = 16'd0;
  logic        cpu_ce, dclk, cpu_rst, running, step_done;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic exp_dclk = 1'b0;

  clk_run_ctrl #(.DIV_W(8), .DEF_DIV(3), .STEP_W(16), .RST_HOLD(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cpu_ce(cpu_ce), .dclk(dclk),
    .cpu_rst(cpu_rst), .running(running), .step_done(step_done),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, want);
    end
  endtask

  // One clock edge; the model tracks dclk and cycle_cnt from the expected pulses.
  task automatic edge_chk(input logic exp_ce, input logic exp_sd);
    @(posedge clk);
    #1;
    if (exp_ce) begin
      exp_cnt++;
      exp_dclk = ~exp_dclk;
    end
    check("cpu_ce", 32'(cpu_ce), 32'(exp_ce));
    check("step_done", 32'(step_done), 32'(exp_sd));
    check("dclk", 32'(dclk), 32'(exp_dclk));
    check("cycle_cnt", cycle_cnt, 32'(exp_cnt));
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] arg,
                      input logic exp_ce, input logic exp_sd);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    edge_chk(exp_ce, exp_sd);
    cmd_valid = 1'b0;
  endtask

  // Pulses at edges first, first+period, ... (npulses<0: unlimited, first==0: none).
  task automatic run_expect(input int n, input int first, input int period,
                            input int npulses, input int sd_at);
    for (int k = 1; k <= n; k++) begin
      logic ce;
      ce = (first > 0) && (k >= first) && (((k - first) % period) == 0) &&
           ((npulses < 0) || (((k - first) / period) < npulses));
      edge_chk(ce, k == sd_at);
    end
  endtask

  // Four ticks at div=3 after rst release: cpu_rst falls on the 16th edge.
  task automatic hold_seq();
    for (int k = 1; k <= 16; k++) begin
      edge_chk(1'b0, 1'b0);
      check("hold_cpu_rst", 32'(cpu_rst), 32'(k < 16));
      check("hold_cmd_ready", 32'(cmd_ready), 32'(k == 16));
    end
  endtask

  task automatic reset_vals();
    check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    check("rst_dclk", 32'(dclk), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_step_done", 32'(step_done), 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_vals();

    // Release reset with a RUN already pending; it waits for cmd_ready.
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    hold_seq();
    edge_chk(1'b0, 1'b0);
    cmd_valid = 1'b0;
    check("run_running", 32'(running), 32'd1);

    run_expect(40, 3, 4, -1, 0);
    check("run_10_pulses", cycle_cnt, 32'd10);
    edge_chk(1'b0, 1'b0);
    edge_chk(1'b0, 1'b0);
    send(OP_HALT, 16'd0, 1'b1, 1'b0);
    check("halt_running", 32'(running), 32'd0);
    run_expect(12, 0, 1, 0, 0);

    send(OP_SET_DIV, 16'd1, 1'b0, 1'b0);
    send(OP_STEP, 16'd5, 1'b0, 1'b0);
    check("step_running", 32'(running), 32'd1);
    run_expect(12, 1, 2, 5, 9);
    check("step_end_running", 32'(running), 32'd0);

    send(OP_STEP, 16'd0, 1'b0, 1'b1);
    edge_chk(1'b0, 1'b0);

    send(OP_STEP, 16'd8, 1'b0, 1'b0);
    run_expect(6, 2, 2, -1, 0);
    send(OP_RUN, 16'd0, 1'b0, 1'b0);
    run_expect(10, 1, 2, -1, 0);

    send(OP_STEP, 16'd2, 1'b1, 1'b0);
    run_expect(8, 2, 2, 2, 4);
    check("step2_running", 32'(running), 32'd0);

    send(OP_RUN, 16'd0, 1'b0, 1'b0);
    send(OP_SET_DIV, 16'd0, 1'b1, 1'b0);
    run_expect(6, 1, 1, -1, 0);
    send(OP_SET_DIV, 16'd7, 1'b1, 1'b0);
    run_expect(24, 8, 8, -1, 0);

    send(OP_STEP, 16'd8, 1'b0, 1'b0);
    run_expect(10, 7, 8, -1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_vals();
    exp_cnt  = 0;
    exp_dclk = 1'b0;
    rst = 1'b0;
    hold_seq();
    check("rehold_running", 32'(running), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
